// File: rtl/noc_local_injector_pkg.sv
// ---------------------------------------------------------------------------
// noc_local_injector_pkg
// Shared NoC parameter set for the local injector:
//   - default network dimensions (VC count, router ID widths)
//   - default injector sizing (credits per VC, max body length, payload width)
//   - flit_type_t : 2-bit flit type carried in the top bits of every flit
//   - noc_head_t  : head-flit payload fields, dest_x in the LSBs
//   - CREDIT_W    : credit counter width for the default credit depth
// ---------------------------------------------------------------------------
package noc_local_injector_pkg;

  localparam int NOC_VC_CHANNEL  = 2;
  localparam int NOC_ID_X_WIDTH  = 4;
  localparam int NOC_ID_Y_WIDTH  = 4;
  localparam int NOC_CREDITS     = 4;
  localparam int NOC_MAX_LEN     = 15;
  localparam int NOC_PAYLOAD_W   = 32;
  localparam int NOC_LEN_W       = $clog2(NOC_MAX_LEN + 1);

  // Counter must hold the full value CREDITS, hence +1.
  function automatic int credit_w(input int credits);
    return $clog2(credits + 1);
  endfunction

  localparam int CREDIT_W = credit_w(NOC_CREDITS);

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_t;

  // Packed MSB-first, so dest_x lands in the least significant bits.
  typedef struct packed {
    logic [NOC_LEN_W-1:0]      len;
    logic [NOC_ID_Y_WIDTH-1:0] src_y;
    logic [NOC_ID_X_WIDTH-1:0] src_x;
    logic [NOC_ID_Y_WIDTH-1:0] dest_y;
    logic [NOC_ID_X_WIDTH-1:0] dest_x;
  } noc_head_t;

endpackage

// File: rtl/noc_credit_counter.sv
// ---------------------------------------------------------------------------
// noc_credit_counter
// Tracks free downstream buffer slots for one virtual channel.
//   i_clk           : clock, rising edge
//   i_rst           : asynchronous active-high reset, count returns to CREDITS
//   i_consume       : a flit was committed to this VC this cycle
//   i_credit_return : downstream freed one slot this cycle
//   o_has_credit    : at least one slot is free
// Simultaneous consume and return cancel out.
// ---------------------------------------------------------------------------
module noc_credit_counter
  import noc_local_injector_pkg::*;
#(
  parameter int CREDITS = NOC_CREDITS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_consume,
  input  logic i_credit_return,
  output logic o_has_credit
);

  localparam int CNT_W = credit_w(CREDITS);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= FULL;
    end else if (i_consume && !i_credit_return) begin
      r_count <= r_count - CNT_W'(1);
    end else if (i_credit_return && !i_consume && (r_count != FULL)) begin
      // A return at FULL is a protocol error; hold at FULL rather than wrap.
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_has_credit = (r_count != '0);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_credit_return && !i_consume && (r_count == FULL)));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_consume && (r_count == '0)));

endmodule

// File: rtl/noc_local_injector.sv
// ---------------------------------------------------------------------------
// noc_local_injector
// Network-interface transmit stage feeding the router's local input port.
// Turns a packet request plus a payload word stream into HEAD/BODY/TAIL
// flits, never sending a flit without a downstream credit on its VC.
//   i_noc_clk / i_noc_rst          : clock, asynchronous active-high reset
//   i_id_x / i_id_y                : this router's coordinates (head source)
//   i_req_valid / o_req_ready      : packet request handshake (ready = idle)
//   i_req_dest_x/_y, i_req_vc, i_req_len : request fields, latched in IDLE
//   i_data_valid / o_data_ready / i_data_payload : body word handshake
//   o_flit_valid                   : one-hot VC valid, one cycle per flit
//   o_flit_out                     : {flit_type, vc, payload}
//   i_credit_return                : per-VC one-cycle slot-freed pulses
//   o_busy                         : packet in progress
// ---------------------------------------------------------------------------
module noc_local_injector
  import noc_local_injector_pkg::*;
#(
  parameter  int CHANNELS  = NOC_VC_CHANNEL,
  parameter  int CREDITS   = NOC_CREDITS,
  parameter  int MAX_LEN   = NOC_MAX_LEN,
  parameter  int PAYLOAD_W = NOC_PAYLOAD_W,
  localparam int LEN_W     = $clog2(MAX_LEN + 1),
  localparam int VC_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FLIT_W    = 2 + VC_W + PAYLOAD_W
) (
  input  logic                      i_noc_clk,
  input  logic                      i_noc_rst,
  input  logic [NOC_ID_X_WIDTH-1:0] i_id_x,
  input  logic [NOC_ID_Y_WIDTH-1:0] i_id_y,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [NOC_ID_X_WIDTH-1:0] i_req_dest_x,
  input  logic [NOC_ID_Y_WIDTH-1:0] i_req_dest_y,
  input  logic [VC_W-1:0]           i_req_vc,
  input  logic [LEN_W-1:0]          i_req_len,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  input  logic [PAYLOAD_W-1:0]      i_data_payload,
  output logic [CHANNELS-1:0]       o_flit_valid,
  output logic [FLIT_W-1:0]         o_flit_out,
  input  logic [CHANNELS-1:0]       i_credit_return,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t                      r_state;
  logic [NOC_ID_X_WIDTH-1:0]   r_dest_x;
  logic [NOC_ID_Y_WIDTH-1:0]   r_dest_y;
  logic [VC_W-1:0]             r_vc;
  logic [LEN_W-1:0]            r_len;
  logic [LEN_W-1:0]            r_remaining;
  logic [CHANNELS-1:0]         r_flit_valid;
  logic [FLIT_W-1:0]           r_flit_out;

  logic [CHANNELS-1:0]         w_has_credit;
  logic [CHANNELS-1:0]         w_vc_onehot;
  logic [CHANNELS-1:0]         w_consume;
  logic                        w_vc_credit;
  logic                        w_head_emit;
  logic                        w_body_emit;
  logic                        w_emit;
  logic [LEN_W-1:0]            w_req_len_clamped;
  noc_head_t                   w_head;
  flit_type_t                  w_flit_type;
  logic [PAYLOAD_W-1:0]        w_flit_payload;

  // Per-VC credit tracking; only the VC of the current packet ever consumes.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_vc
      assign w_vc_onehot[gi] = (r_vc == VC_W'(gi));
      assign w_consume[gi]   = w_emit && w_vc_onehot[gi];

      noc_credit_counter #(
        .CREDITS(CREDITS)
      ) u_credit (
        .i_clk          (i_noc_clk),
        .i_rst          (i_noc_rst),
        .i_consume      (w_consume[gi]),
        .i_credit_return(i_credit_return[gi]),
        .o_has_credit   (w_has_credit[gi])
      );
    end
  endgenerate

  assign w_vc_credit  = w_has_credit[r_vc];
  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_data_ready = (r_state == ST_BODY) && w_vc_credit;
  assign w_head_emit  = (r_state == ST_HEAD) && w_vc_credit;
  assign w_body_emit  = o_data_ready && i_data_valid;
  assign w_emit       = w_head_emit || w_body_emit;

  // Widened compare so the clamp stays meaningful when MAX_LEN fills LEN_W.
  assign w_req_len_clamped = ({1'b0, i_req_len} > (LEN_W + 1)'(MAX_LEN)) ?
                             LEN_W'(MAX_LEN) : i_req_len;

  always_comb begin
    w_head        = '0;
    w_head.dest_x = r_dest_x;
    w_head.dest_y = r_dest_y;
    w_head.src_x  = i_id_x;
    w_head.src_y  = i_id_y;
    w_head.len    = NOC_LEN_W'(r_len);
  end

  // Type/payload of the flit that would be committed this cycle.
  always_comb begin
    w_flit_type    = FLIT_BODY;
    w_flit_payload = i_data_payload;
    if (r_state == ST_HEAD) begin
      w_flit_type    = (r_len == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
      w_flit_payload = PAYLOAD_W'(w_head);
    end else if (r_remaining == LEN_W'(1)) begin
      w_flit_type = FLIT_TAIL;
    end
  end

  always_ff @(posedge i_noc_clk or posedge i_noc_rst) begin
    if (i_noc_rst) begin
      r_state      <= ST_IDLE;
      r_dest_x     <= '0;
      r_dest_y     <= '0;
      r_vc         <= '0;
      r_len        <= '0;
      r_remaining  <= '0;
      r_flit_valid <= '0;
      r_flit_out   <= '0;
    end else begin
      r_flit_valid <= '0;
      if (w_emit) begin
        r_flit_valid <= w_vc_onehot;
        r_flit_out   <= {w_flit_type, r_vc, w_flit_payload};
      end

      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_dest_x <= i_req_dest_x;
            r_dest_y <= i_req_dest_y;
            r_vc     <= i_req_vc;
            r_len    <= w_req_len_clamped;
            r_state  <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (w_head_emit) begin
            if (r_len == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_remaining <= r_len;
              r_state     <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (w_body_emit) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_flit_valid = r_flit_valid;
  assign o_flit_out   = r_flit_out;

  a_req_len_legal: assert property (@(posedge i_noc_clk) disable iff (i_noc_rst)
    (o_req_ready && i_req_valid) |-> ({1'b0, i_req_len} <= (LEN_W + 1)'(MAX_LEN)));

endmodule

// File: tb/tb_noc_local_injector.sv
// ---------------------------------------------------------------------------
// tb_noc_local_injector
// Directed bench: a table of packets run with a credit-returning sink, then
// hand sequences for credit exhaustion, coincident return/consume and a
// mid-packet reset. Flits are matched in order against an expected queue.
// ---------------------------------------------------------------------------
module tb_noc_local_injector;
  import noc_local_injector_pkg::*;

  localparam int CH = 2;
  localparam int VW = 1;
  localparam int LW = 4;
  localparam int PW = 32;
  localparam int FW = 2 + VW + PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    id_x = 4'd1;
  logic [3:0]    id_y = 4'd2;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_dest_x = '0;
  logic [3:0]    req_dest_y = '0;
  logic [VW-1:0] req_vc = '0;
  logic [LW-1:0] req_len = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [PW-1:0] data_payload = '0;
  logic [CH-1:0] flit_valid;
  logic [FW-1:0] flit_out;
  logic [CH-1:0] credit_return = '0;
  logic          busy;

  always #5 clk = ~clk;

  noc_local_injector dut (
    .i_noc_clk     (clk),
    .i_noc_rst     (rst),
    .i_id_x        (id_x),
    .i_id_y        (id_y),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_dest_x  (req_dest_x),
    .i_req_dest_y  (req_dest_y),
    .i_req_vc      (req_vc),
    .i_req_len     (req_len),
    .i_data_valid  (data_valid),
    .o_data_ready  (data_ready),
    .i_data_payload(data_payload),
    .o_flit_valid  (flit_valid),
    .o_flit_out    (flit_out),
    .i_credit_return(credit_return),
    .o_busy        (busy)
  );

  typedef struct {
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic        vc;
    int          len;
    logic [31:0] base;
    bit          gap;
    logic [1:0]  ftype;
    logic [31:0] head;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          busy_cnt = 0;
  int          req_cyc  = 0;
  bit          auto_credit = 1'b0;
  logic [63:0] exp_q[$];
  int          got_cyc[$];
  vec_t        tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // {flit_valid, flit_type, vc, payload}
  function automatic logic [63:0] mk_flit(input logic [1:0] t, input logic vc, input logic [31:0] p);
    logic [CH-1:0] v;
    v     = '0;
    v[vc] = 1'b1;
    return 64'({v, t, vc, p});
  endfunction

  // Advance one clock; observe at the falling edge. The sink returns a
  // credit for every flit it sees when auto_credit is on.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (busy) busy_cnt++;
    if (flit_valid != '0) begin
      got_cyc.push_back(cycle);
      if (exp_q.size() == 0) check("unexpected_flit", 64'({flit_valid, flit_out}), 64'd0);
      else check("flit", 64'({flit_valid, flit_out}), exp_q.pop_front());
    end
    credit_return = auto_credit ? flit_valid : '0;
  endtask

  task automatic push_exp(input logic [1:0] ft, input logic vc, input int len,
                          input logic [31:0] head, input logic [31:0] base);
    exp_q.push_back(mk_flit(ft, vc, head));
    for (int i = 0; i < len; i++)
      exp_q.push_back(mk_flit((i == len - 1) ? 2'b10 : 2'b00, vc, base + 32'(i)));
  endtask

  task automatic req_issue(input logic [3:0] dx, input logic [3:0] dy, input logic vc, input int len);
    int k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_dest_x = dx;
    req_dest_y = dy;
    req_vc     = vc;
    req_len    = LW'(len);
    got_cyc.delete();
    busy_cnt = 0;
    req_cyc  = cycle;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain_and_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    check("ready_after_tail", 64'(req_ready), 64'd1);
  endtask

  task automatic send_packet(input vec_t v);
    int i = 0;
    int k = 0;
    int last;
    push_exp(v.ftype, v.vc, v.len, v.head, v.base);
    req_issue(v.dx, v.dy, v.vc, v.len);
    while (i < v.len && k < 300) begin
      data_valid   = v.gap ? (k % 3 == 0) : 1'b1;
      data_payload = v.base + 32'(i);
      if (data_valid && data_ready) i++;
      tick();
      k++;
    end
    data_valid = 1'b0;
    drain_and_idle();
    if (!v.gap) begin
      last = (got_cyc.size() > 0) ? got_cyc[$] : -100;
      check("first_flit_latency", 64'((got_cyc.size() > 0) ? got_cyc[0] - req_cyc : -1), 64'd2);
      check("last_flit_cycle", 64'(last - req_cyc), 64'(2 + v.len));
      check("busy_cycles", 64'(busy_cnt), 64'(v.len + 1));
    end
    $display("packet vc=%0d len=%0d head=0x%08h gap=%0d flits=%0d cycle=%0d",
             v.vc, v.len, v.head, v.gap, got_cyc.size(), cycle);
  endtask

  // Packet sent with the sink silent: expect exp_bodies body flits before
  // the credit stall, then release the rest one credit at a time.
  task automatic run_limited(input logic [3:0] dx, input logic [3:0] dy, input logic vc,
                             input int len, input logic [31:0] head, input logic [31:0] base,
                             input bit coincide, input int exp_bodies, input int restore);
    int nb = 0;
    int k  = 0;
    int c;
    push_exp(2'b01, vc, len, head, base);
    req_issue(dx, dy, vc, len);
    if (coincide) credit_return[vc] = 1'b1;   // lands on the head emit edge
    while (k < 20) begin
      data_valid   = 1'b1;
      data_payload = base + 32'(nb);
      if (data_ready && nb < len) nb++;
      else if (got_cyc.size() > 0) break;
      tick();
      k++;
    end
    check("bodies_before_stall", 64'(nb), 64'(exp_bodies));
    check("stall_ready", 64'(data_ready), 64'd0);
    tick();
    check("stall_ready_hold", 64'(data_ready), 64'd0);
    check("stalled_flits_held", 64'(exp_q.size()), 64'(len - nb));
    k = 0;
    while (nb < len && k < 20) begin
      credit_return[vc] = 1'b1;
      c = cycle;
      tick();
      check("release_ready", 64'(data_ready), 64'd1);
      data_payload = base + 32'(nb);
      nb++;
      tick();
      check("release_latency", 64'((got_cyc.size() > 0) ? got_cyc[$] - c : -1), 64'd2);
      k++;
    end
    data_valid = 1'b0;
    drain_and_idle();
    for (int j = 0; j < restore; j++) begin
      credit_return[vc] = 1'b1;
      tick();
    end
    tick();
    $display("limited packet vc=%0d len=%0d coincide=%0d bodies_before_stall=%0d cycle=%0d",
             vc, len, coincide, exp_bodies, cycle);
  endtask

  initial begin
    int i;
    int k;

    tbl[0] = '{4'd2,  4'd3,  1'b1, 0,  32'h0000_0000, 1'b0, 2'b11, 32'h0000_2132};
    tbl[1] = '{4'd5,  4'd6,  1'b0, 3,  32'hA000_0000, 1'b0, 2'b01, 32'h0003_2165};
    tbl[2] = '{4'd15, 4'd0,  1'b1, 1,  32'hB000_0010, 1'b0, 2'b01, 32'h0001_210F};
    tbl[3] = '{4'd0,  4'd15, 1'b0, 2,  32'h1234_5678, 1'b0, 2'b01, 32'h0002_21F0};
    tbl[4] = '{4'd7,  4'd7,  1'b1, 15, 32'hD000_0000, 1'b0, 2'b01, 32'h000F_2177};
    tbl[5] = '{4'd3,  4'd1,  1'b0, 4,  32'hE000_0000, 1'b1, 2'b01, 32'h0004_2113};

    // Reset state
    #2;
    check("rst_flit_valid", 64'(flit_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_flit_out", 64'(flit_out), 64'd0);
    check("idle_req_ready", 64'(req_ready), 64'd1);

    // Table-driven packets with a credit-returning sink
    auto_credit = 1'b1;
    for (int t = 0; t < 6; t++) send_packet(tbl[t]);
    for (int t = 0; t < 3; t++) tick();
    auto_credit = 1'b0;
    tick();

    // Exhaustion on vc0: head + 3 bodies, tail waits for a credit; leave 2 credits
    run_limited(4'd1, 4'd1, 1'b0, 4, 32'h0004_2111, 32'h5000_0000, 1'b0, 3, 2);
    // Return coincident with head emit keeps the count at 2
    run_limited(4'd6, 4'd2, 1'b0, 3, 32'h0003_2126, 32'h6000_0000, 1'b1, 2, 4);

    // Reset in the middle of a body stream
    auto_credit = 1'b1;
    push_exp(2'b01, 1'b1, 5, 32'h0005_2144, 32'hC000_0000);
    req_issue(4'd4, 4'd4, 1'b1, 5);
    i = 0;
    k = 0;
    while (got_cyc.size() < 2 && k < 20) begin
      data_valid   = 1'b1;
      data_payload = 32'hC000_0000 + 32'(i);
      if (data_ready) i++;
      tick();
      k++;
    end
    check("pre_rst_valid", 64'(flit_valid), 64'd2);
    #1;
    rst           = 1'b1;
    credit_return = '0;
    auto_credit   = 1'b0;
    data_valid    = 1'b0;
    #1;
    check("midrst_flit_valid", 64'(flit_valid), 64'd0);
    check("midrst_flit_out", 64'(flit_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_data_ready", 64'(data_ready), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    $display("reset applied mid-packet at cycle %0d", cycle);
    tick();
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Clean packet after reset: full 4 credits on vc1 again
    run_limited(4'd9, 4'd8, 1'b1, 4, 32'h0004_2189, 32'h7000_0000, 1'b0, 3, 4);

    auto_credit = 1'b1;
    send_packet(tbl[1]);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
